// File: rtl/hpdsm_feeder.sv
// Sample feeder for a high-precision delta-sigma modulator: one sample per 2^n clocks.
// Define HPDSM_FEEDER_INTERP_EN for linear interpolation between samples.
module hpdsm_feeder #(
  parameter int WIDTH        = 16,
  parameter int OSR_MAX_LOG2 = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [3:0]       osr_log2,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] dsm_x,
  output logic             dsm_rst,
  output logic             tick,
  output logic             busy,
  output logic             underflow,
  input  logic             underflow_clr
);

  localparam int CW = (OSR_MAX_LOG2 > 0) ? OSR_MAX_LOG2 : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    STOP
  } state_t;

  state_t           r_state;
  logic [3:0]       r_n;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_next;
  logic             r_next_full;
  logic             r_underflow;

  logic [CW-1:0]    w_mask;
  logic             w_active;
  logic             w_tick;
  logic             w_ready;
  logic             w_xfer;
  logic [3:0]       w_osr_clamped;
  logic             w_uf_set;
  logic [WIDTH-1:0] w_cur_nxt;

  assign w_mask   = ~({CW{1'b1}} << r_n);
  assign w_active = (r_state == RUN) || (r_state == STOP);
  assign w_tick   = w_active && (r_cnt == w_mask);

  assign w_ready = (r_state == PRIME) ||
                   ((r_state == RUN) && (!r_next_full || w_tick));
  assign w_xfer  = s_valid && w_ready;

  assign w_osr_clamped = (int'(osr_log2) > OSR_MAX_LOG2) ?
                         4'(OSR_MAX_LOG2) : osr_log2;

  assign w_uf_set = (r_state == RUN) && w_tick &&
                    !r_next_full && !w_xfer;

  // Value CUR takes at a tick in RUN
  always_comb begin
    w_cur_nxt = '0;
    if (r_next_full) begin
      w_cur_nxt = r_next;
    end else if (w_xfer) begin
      w_cur_nxt = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_next      <= '0;
      r_next_full <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_cur       <= '0;
          r_next_full <= 1'b0;
          if (enable) begin
            r_state <= PRIME;
            r_n     <= w_osr_clamped;
          end
        end
        PRIME: begin
          if (w_xfer) begin
            r_state     <= RUN;
            r_cur       <= s_data;
            r_cnt       <= '0;
            r_next_full <= 1'b0;
          end else if (!enable) begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
          if (w_tick) begin
            r_cur       <= w_cur_nxt;
            r_next_full <= r_next_full && w_xfer;
            if (r_next_full && w_xfer) begin
              r_next <= s_data;
            end
          end else if (w_xfer) begin
            r_next      <= s_data;
            r_next_full <= 1'b1;
          end
          if (!enable) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
          if (w_tick) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_next_full <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Set wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (w_uf_set) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

`ifdef HPDSM_FEEDER_INTERP_EN
  localparam int AW = WIDTH + 1 + CW;

  logic        [WIDTH-1:0] r_prev;
  logic signed [WIDTH:0]   r_step;
  logic signed [AW-1:0]    r_acc;

  logic        [AW-1:0]    w_cur_ext;
  logic        [AW-1:0]    w_step_ext;
  logic signed [WIDTH:0]   w_step_new;
  logic signed [AW-1:0]    w_shr;

  assign w_cur_ext  = {{(CW + 1){r_cur[WIDTH-1]}}, r_cur};
  assign w_step_ext = {{CW{r_step[WIDTH]}}, r_step};
  assign w_step_new = $signed({w_cur_nxt[WIDTH-1], w_cur_nxt}) -
                      $signed({r_cur[WIDTH-1], r_cur});
  assign w_shr      = r_acc >>> r_n;

  // Ramp from PREV to CUR across one period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_step <= '0;
      r_acc  <= '0;
    end else if (r_state == PRIME) begin
      r_prev <= '0;
      r_acc  <= '0;
      r_step <= $signed({s_data[WIDTH-1], s_data});
    end else if ((r_state == RUN) && w_tick) begin
      r_prev <= r_cur;
      r_acc  <= $signed(w_cur_ext << r_n);
      r_step <= w_step_new;
    end else if (w_active) begin
      r_acc <= r_acc + $signed(w_step_ext);
    end else begin
      r_prev <= '0;
      r_step <= '0;
      r_acc  <= '0;
    end
  end

  assign dsm_x = w_active ? w_shr[WIDTH-1:0] : '0;
`else
  assign dsm_x = w_active ? r_cur : '0;
`endif

  assign s_ready   = w_ready;
  assign dsm_rst   = (r_state == IDLE) || (r_state == PRIME);
  assign tick      = w_tick;
  assign busy      = (r_state != IDLE);
  assign underflow = r_underflow;

endmodule

// File: tb/tb_hpdsm_feeder.sv
// Randomized scoreboard bench for hpdsm_feeder (zero-order-hold build).
// Expected outputs come from a period/queue model; a negedge monitor compares.
module tb_hpdsm_feeder;

  localparam int W  = 16;
  localparam int ML = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic [3:0]   osr_log2 = '0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         underflow_clr = 1'b0;
  logic         s_ready;
  logic [W-1:0] dsm_x;
  logic         dsm_rst;
  logic         tick;
  logic         busy;
  logic         underflow;

  hpdsm_feeder #(.WIDTH(W), .OSR_MAX_LOG2(ML)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .osr_log2     (osr_log2),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dsm_x        (dsm_x),
    .dsm_rst      (dsm_rst),
    .tick         (tick),
    .busy         (busy),
    .underflow    (underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] x;
    logic         rdy;
    logic         tk;
    logic         bsy;
    logic         drst;
    logic         uf;
  } exp_t;

  exp_t expq[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: 0 idle, 1 prime, 2 run, 3 stop
  int           md = 0;
  int           n = 0;
  longint       cyc = 0;
  longint       start = 0;
  logic [W-1:0] cur = '0;
  logic [W-1:0] pend[$];
  logic [W-1:0] src[$];
  bit           uf = 1'b0;

  bit           l_en = 0, l_valid = 0, l_clr = 0;
  bit           l_rdy = 0, l_tk = 0;
  logic [3:0]   l_osr = '0;
  logic [W-1:0] l_data = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t expect_now();
    exp_t   e;
    longint p;
    bit     tk;
    p      = longint'(1) << n;
    tk     = (md == 2 || md == 3) && (((cyc - start) % p) == p - 1);
    e.x    = (md == 2 || md == 3) ? cur : '0;
    e.tk   = tk;
    e.rdy  = (md == 1) || (md == 2 && (pend.size() == 0 || tk));
    e.bsy  = (md != 0);
    e.drst = (md < 2);
    e.uf   = uf;
    return e;
  endfunction

  task automatic model_edge();
    bit xfer;
    bit set;
    xfer = l_valid && l_rdy;
    set  = 0;
    if (xfer) void'(src.pop_front());
    case (md)
      0: if (l_en) begin
        md = 1;
        n  = (l_osr > ML) ? ML : int'(l_osr);
      end
      1: if (xfer) begin
        md = 2;
        cur = l_data;
        pend.delete();
        start = cyc;
      end else if (!l_en) begin
        md = 0;
      end
      2: begin
        if (l_tk) begin
          if (pend.size() > 0) begin
            cur = pend.pop_front();
            if (xfer) pend.push_back(l_data);
          end else if (xfer) begin
            cur = l_data;
          end else begin
            cur = '0;
            set = 1;
          end
        end else if (xfer) begin
          pend.push_back(l_data);
        end
        if (!l_en) md = 3;
      end
      default: if (l_tk) begin
        md = 0;
        cur = '0;
        pend.delete();
      end
    endcase
    if (set) uf = 1;
    else if (l_clr) uf = 0;
  endtask

  task automatic step(input bit en, input logic [3:0] osr,
                      input int vpct, input bit clr);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    enable        = en;
    osr_log2      = osr;
    underflow_clr = clr;
    s_valid = (src.size() > 0) && (int'($urandom_range(99)) < vpct);
    s_data  = s_valid ? src[0] : W'($urandom);
    e       = expect_now();
    l_en    = en;
    l_osr   = osr;
    l_clr   = clr;
    l_valid = s_valid;
    l_data  = s_data;
    l_rdy   = e.rdy;
    l_tk    = e.tk;
    expq.push_back(e);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_dsm_x"}, dsm_x, 0);
    check({tag, "_dsm_rst"}, dsm_rst, 1);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underflow"}, underflow, 0);
  endtask

  // Reset dropped between clock edges with a valid sample offered
  task automatic mid_reset();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    #2 rst_n = 1'b0;
    #1 reset_check("async_rst");
    md  = 0;
    cur = '0;
    uf  = 0;
    pend.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    l_en    = enable;
    l_osr   = osr_log2;
    l_valid = s_valid;
    l_data  = s_data;
    l_clr   = underflow_clr;
    l_rdy   = 0;
    l_tk    = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("dsm_x", dsm_x, e.x);
      check("s_ready", s_ready, e.rdy);
      check("tick", tick, e.tk);
      check("busy", busy, e.bsy);
      check("dsm_rst", dsm_rst, e.drst);
      check("underflow", underflow, e.uf);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int osr;
    int vp;
    int len;
    #1 rst_n = 1'b0;
    #11 reset_check("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-order hold, 4 clocks per sample
    src = '{16'd100, 16'd200, 16'd300};
    repeat (15) step(1, 4'd2, 100, 0);
    repeat (8) step(0, 4'd2, 100, 0);
    step(0, 4'd2, 0, 1);

    // Single sample then starvation, then clear
    src.push_back(16'h1234);
    repeat (20) step(1, 4'd3, 100, 0);
    step(1, 4'd3, 0, 1);
    repeat (3) step(1, 4'd3, 0, 0);
    repeat (10) step(0, 4'd3, 0, 0);
    step(0, 4'd3, 0, 1);

    // Stop requested mid-period
    repeat (6) src.push_back(W'($urandom));
    repeat (8) step(1, 4'd2, 100, 0);
    repeat (8) step(0, 4'd2, 100, 0);

    // Clamp to 4096 and ignore osr changes while busy
    repeat (3) src.push_back(W'($urandom));
    step(1, 4'd15, 100, 0);
    repeat (8200) step(1, 4'd1, 100, 0);
    repeat (4100) step(0, 4'd1, 100, 1);

    // Asynchronous reset mid-run
    src.delete();
    repeat (6) src.push_back(W'($urandom));
    repeat (7) step(1, 4'd1, 100, 0);
    mid_reset();
    repeat (12) step(1, 4'd1, 100, 0);
    repeat (6) step(0, 4'd1, 100, 0);

    for (int ep = 0; ep < 40; ep++) begin
      osr = int'($urandom_range(0, 4));
      vp  = int'($urandom_range(20, 100));
      len = int'($urandom_range(5, 60));
      repeat ($urandom_range(0, 3)) src.push_back(W'($urandom));
      for (int i = 0; i < len; i++) begin
        if (src.size() < 2 && $urandom_range(1) == 1)
          src.push_back(W'($urandom));
        step(1, (i == 0) ? 4'(osr) : 4'($urandom), vp,
             $urandom_range(19) == 0);
      end
      if (ep % 8 == 5) mid_reset();
      repeat (20) step(0, 4'($urandom), vp, $urandom_range(9) == 0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
